multicycle_control_unit: RTL and testbench

Multicycle successor to the single-cycle ARM control unit. Sequences each instruction through a fetch/decode/execute state machine and holds the NZCV flag register and the latched condition result. It drives the shared-memory multicycle datapath: one memory port and one ALU reused for PC increment. Parametrised for ALU control width and memory read latency.

---
 rtl/multicycle_control_unit_if.sv | 42 ++++
 rtl/multicycle_control_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Instruction-field and control-strobe bundle between the multicycle
// control unit (master) and the shared-memory datapath (slave).
interface multicycle_control_unit_if #(
  parameter int ALUC_W = 3
);
  logic [3:0]        Cond;
  logic [1:0]        Op;
  logic [5:0]        Funct;
  logic [3:0]        Rd;
  logic [11:0]       Src2;
  logic [3:0]        ALUFlags;

  logic              PCWrite;
  logic              AdrSrc;
  logic              MemWrite;
  logic              IRWrite;
  logic [1:0]        ResultSrc;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [1:0]        ImmSrc;
  logic [1:0]        RegSrc;
  logic              RegWrite;
  logic [ALUC_W-1:0] ALUControl;
  logic              Shift;
  logic [3:0]        State;

  modport master (
    input  Cond, Op, Funct, Rd, Src2, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    output RegSrc, RegWrite, ALUControl, Shift,
    output State
  );

  modport slave (
    output Cond, Op, Funct, Rd, Src2, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    input  RegSrc, RegWrite, ALUControl, Shift,
    input  State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control FSM with NZCV flags and latched condition.
// Optional CU_SHIFT_EN enables the Shift output for register-shifted MOV.
module multicycle_control_unit #(
  parameter int ALUC_W  = 3,
  parameter int MEM_LAT = 0
) (
  input logic clk,
  input logic reset,
  multicycle_control_unit_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  localparam logic [3:0] C_ADD = 4'b0100;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_ORR = 4'b1100;
  localparam logic [3:0] C_EOR = 4'b0001;
  localparam logic [3:0] C_MOV = 4'b1101;
  localparam logic [3:0] C_CMP = 4'b1010;

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [3:0] cmd;
  logic       cnt_done;
  logic       wait_st;
  logic       in_exec;
  logic       cond_ok;
  logic [1:0] flag_w;
  logic [2:0] aluc;
  logic       no_write;
  logic       shift_en;

  logic       pc_w, ir_w, mem_w, reg_w;
  logic       adr, srca;
  logic [1:0] res, srcb;

  assign cmd      = bus.Funct[4:1];
  assign cnt_done = (cnt_q == LAT);
  assign wait_st  = (state_q == S_FETCH) ||
                    (state_q == S_MEMREAD);
  assign in_exec  = (state_q == S_EXECR) ||
                    (state_q == S_EXECI);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (cnt_done) state_d = S_DECODE;
      S_DECODE:
        unique case (bus.Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = bus.Funct[5] ? S_EXECI
                                          : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      S_MEMADR:
        state_d = bus.Funct[0] ? S_MEMREAD
                               : S_MEMWRITE;
      S_MEMREAD:
        if (cnt_done) state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Staying in a wait state implies not done, so leaving always clears.
  always_comb begin
    cnt_d = '0;
    if (wait_st && !cnt_done) cnt_d = cnt_q + 4'd1;
  end

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    unique case (bus.Cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = ~fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = ~fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = ~fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = ~fv;
      4'b1000: cond_ok = fc & ~fz;
      4'b1001: cond_ok = ~fc | fz;
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = ~fz & (fn == fv);
      4'b1101: cond_ok = fz | (fn != fv);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign condex_d = (state_q == S_DECODE) ? cond_ok
                                          : condex_q;

  always_comb begin
    aluc     = 3'b000;
    no_write = 1'b0;
    unique case (cmd)
      C_ADD:   aluc = 3'b000;
      C_SUB:   aluc = 3'b001;
      C_AND:   aluc = 3'b010;
      C_ORR:   aluc = 3'b011;
      C_EOR:   aluc = 3'b100;
      C_MOV:   aluc = 3'b101;
      C_CMP: begin
        aluc     = 3'b001;
        no_write = 1'b1;
      end
      default: aluc = 3'b000;
    endcase
  end

  assign flag_w[1] = bus.Funct[0];
  assign flag_w[0] = bus.Funct[0] &
                     ((cmd == C_ADD) ||
                      (cmd == C_SUB) ||
                      (cmd == C_CMP));

  always_comb begin
    flags_d = flags_q;
    if (in_exec && condex_q) begin
      if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  always_comb begin
    pc_w  = 1'b0;
    ir_w  = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    adr   = 1'b0;
    srca  = 1'b0;
    res   = 2'b00;
    srcb  = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        srca = 1'b1;
        srcb = 2'b10;
        res  = 2'b10;
        ir_w = cnt_done;
        pc_w = cnt_done;
      end
      S_DECODE: begin
        srca = 1'b1;
        srcb = 2'b10;
        res  = 2'b10;
      end
      S_MEMADR:  srcb = 2'b01;
      S_MEMREAD: adr  = 1'b1;
      S_MEMWB: begin
        res   = 2'b01;
        reg_w = condex_q;
        pc_w  = condex_q & (bus.Rd == 4'd15);
      end
      S_MEMWRITE: begin
        adr   = 1'b1;
        mem_w = condex_q;
      end
      S_EXECR: srcb = 2'b00;
      S_EXECI: srcb = 2'b01;
      // Rd=15 writeback also loads the PC through the result bus.
      S_ALUWB: begin
        reg_w = condex_q & ~no_write;
        pc_w  = condex_q & ~no_write &
                (bus.Rd == 4'd15);
      end
      S_BRANCH: begin
        srcb = 2'b01;
        res  = 2'b10;
        pc_w = condex_q;
      end
      default: ;
    endcase
  end

`ifdef CU_SHIFT_EN
  assign shift_en = (state_q == S_EXECR) &&
                    (cmd == C_MOV) &&
                    (bus.Src2[11:4] != 8'd0);
`else
  assign shift_en = 1'b0;
`endif

  always_comb begin
    bus.ALUControl = '0;
    if (in_exec) bus.ALUControl[2:0] = aluc;
  end

  assign bus.PCWrite   = pc_w;
  assign bus.IRWrite   = ir_w;
  assign bus.MemWrite  = mem_w;
  assign bus.RegWrite  = reg_w;
  assign bus.AdrSrc    = adr;
  assign bus.ALUSrcA   = srca;
  assign bus.ResultSrc = res;
  assign bus.ALUSrcB   = srcb;
  assign bus.ImmSrc    = bus.Op;
  assign bus.RegSrc    = {bus.Op == 2'b10,
                          bus.Op == 2'b01};
  assign bus.Shift     = shift_en;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction table on a MEM_LAT=0
// instance, hand sequences on a MEM_LAT=2 instance, per-cycle scoreboard.
module tb_multicycle_control_unit;

`ifdef CU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [11:0] src2;
  logic [3:0]  aflg;

  multicycle_control_unit_if #(.ALUC_W(4)) ifc0 ();
  multicycle_control_unit_if #(.ALUC_W(3)) ifc2 ();

  assign ifc0.Cond = cond;
  assign ifc0.Op = op;
  assign ifc0.Funct = funct;
  assign ifc0.Rd = rd;
  assign ifc0.Src2 = src2;
  assign ifc0.ALUFlags = aflg;
  assign ifc2.Cond = cond;
  assign ifc2.Op = op;
  assign ifc2.Funct = funct;
  assign ifc2.Rd = rd;
  assign ifc2.Src2 = src2;
  assign ifc2.ALUFlags = aflg;

  multicycle_control_unit #(
    .ALUC_W(4), .MEM_LAT(0)
  ) dut0 (.clk(clk), .reset(reset), .bus(ifc0));

  multicycle_control_unit #(
    .ALUC_W(3), .MEM_LAT(2)
  ) dut2 (.clk(clk), .reset(reset), .bus(ifc2));

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [3:0]  flg;
    logic        cex;
    logic [2:0]  aluc;
    logic        nowr;
    logic        shf;
    logic [3:0]  eflags;
  } rec_t;

  int nchk = 0;
  int nerr = 0;
  logic [22:0] sbq[$];

  function automatic rec_t mk(
    input logic [3:0] c, input logic [1:0] o,
    input logic [5:0] f, input logic [3:0] r,
    input logic [11:0] s, input logic [3:0] fl,
    input logic cx, input logic [2:0] al,
    input logic nw, input logic sh,
    input logic [3:0] ef);
    rec_t t;
    t.cond = c; t.op = o; t.funct = f; t.rd = r;
    t.src2 = s; t.flg = fl; t.cex = cx; t.aluc = al;
    t.nowr = nw; t.shf = sh; t.eflags = ef;
    return t;
  endfunction

  function automatic logic [22:0] pk(
    input logic [3:0] st, input logic pcw,
    input logic irw, input logic memw,
    input logic regw, input logic adr,
    input logic srca, input logic [1:0] res,
    input logic [1:0] srcb, input logic [2:0] al,
    input logic sh, input logic [1:0] o);
    logic [1:0] rs;
    rs = {o == 2'b10, o == 2'b01};
    return {st, pcw, irw, memw, regw, adr, srca,
            res, srcb, 1'b0, al, sh, o, rs};
  endfunction

  function automatic logic [22:0] obs(input int sel);
    if (sel == 0)
      return {ifc0.State, ifc0.PCWrite, ifc0.IRWrite,
              ifc0.MemWrite, ifc0.RegWrite, ifc0.AdrSrc,
              ifc0.ALUSrcA, ifc0.ResultSrc, ifc0.ALUSrcB,
              ifc0.ALUControl, ifc0.Shift, ifc0.ImmSrc,
              ifc0.RegSrc};
    return {ifc2.State, ifc2.PCWrite, ifc2.IRWrite,
            ifc2.MemWrite, ifc2.RegWrite, ifc2.AdrSrc,
            ifc2.ALUSrcA, ifc2.ResultSrc, ifc2.ALUSrcB,
            1'b0, ifc2.ALUControl, ifc2.Shift,
            ifc2.ImmSrc, ifc2.RegSrc};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Called at a negedge with the DUT in FETCH, wait count 0.
  task automatic run(input rec_t r, input int sel,
                     input int idx);
    int lat;
    int cyc;
    logic [3:0] st;
    logic w;
    lat = (sel == 0) ? 0 : 2;
    cond = r.cond; op = r.op; funct = r.funct;
    rd = r.rd; src2 = r.src2; aflg = r.flg;
    for (int i = 0; i <= lat; i++)
      sbq.push_back(pk(4'd0, i == lat, i == lat, 0, 0, 0,
                       1, 2'b10, 2'b10, 3'd0, 0, r.op));
    sbq.push_back(pk(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10,
                     3'd0, 0, r.op));
    case (r.op)
      2'b01: begin
        sbq.push_back(pk(4'd2, 0, 0, 0, 0, 0, 0, 2'b00,
                         2'b01, 3'd0, 0, r.op));
        if (r.funct[0]) begin
          for (int i = 0; i <= lat; i++)
            sbq.push_back(pk(4'd3, 0, 0, 0, 0, 1, 0, 2'b00,
                             2'b00, 3'd0, 0, r.op));
          sbq.push_back(pk(4'd4, r.cex & (r.rd == 4'd15),
                           0, 0, r.cex, 0, 0, 2'b01, 2'b00,
                           3'd0, 0, r.op));
        end else begin
          sbq.push_back(pk(4'd5, 0, 0, r.cex, 0, 1, 0, 2'b00,
                           2'b00, 3'd0, 0, r.op));
        end
      end
      2'b00: begin
        st = r.funct[5] ? 4'd7 : 4'd6;
        sbq.push_back(pk(st, 0, 0, 0, 0, 0, 0, 2'b00,
                         r.funct[5] ? 2'b01 : 2'b00, r.aluc,
                         r.shf & SHIFT_EN & (st == 4'd6),
                         r.op));
        w = r.cex & ~r.nowr;
        sbq.push_back(pk(4'd8, w & (r.rd == 4'd15), 0, 0, w,
                         0, 0, 2'b00, 2'b00, 3'd0, 0, r.op));
      end
      2'b10:
        sbq.push_back(pk(4'd9, r.cex, 0, 0, 0, 0, 0, 2'b10,
                         2'b01, 3'd0, 0, r.op));
      default: ;
    endcase
    #1;
    cyc = 0;
    while (sbq.size() > 0) begin
      logic [22:0] e;
      e = sbq.pop_front();
      chk($sformatf("r%0d.%0d cyc%0d", sel, idx, cyc),
          32'(obs(sel)), 32'(e));
      cyc++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk($sformatf("r%0d.%0d flags", sel, idx),
        32'(sel == 0 ? dut0.flags_q : dut2.flags_q),
        32'(r.eflags));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  rec_t tbl[20];
  rec_t r2;

  initial begin
    cond = 4'hE; op = 2'b00; funct = '0;
    rd = '0; src2 = '0; aflg = '0;
    reset = 1'b1;

    tbl[0]  = mk(4'hE,2'b01,6'b011001,4'd1,12'h0,4'h0,1,3'd0,0,0,4'h0);
    tbl[1]  = mk(4'hE,2'b01,6'b011000,4'd1,12'h0,4'h0,1,3'd0,0,0,4'h0);
    tbl[2]  = mk(4'hE,2'b00,6'b001000,4'd1,12'h0,4'h0,1,3'd0,0,0,4'h0);
    tbl[3]  = mk(4'hE,2'b00,6'b000101,4'd1,12'h0,4'h4,1,3'd1,0,0,4'h4);
    tbl[4]  = mk(4'h0,2'b10,6'b000000,4'd0,12'h0,4'h0,1,3'd0,0,0,4'h4);
    tbl[5]  = mk(4'hE,2'b00,6'b100101,4'd1,12'h0,4'h0,1,3'd1,0,0,4'h0);
    tbl[6]  = mk(4'h0,2'b10,6'b000000,4'd0,12'h0,4'h0,0,3'd0,0,0,4'h0);
    tbl[7]  = mk(4'h1,2'b10,6'b000000,4'd0,12'h0,4'h0,1,3'd0,0,0,4'h0);
    tbl[8]  = mk(4'hE,2'b00,6'b010101,4'd1,12'h0,4'hA,1,3'd1,1,0,4'hA);
    tbl[9]  = mk(4'hE,2'b00,6'b000001,4'd1,12'h0,4'h6,1,3'd2,0,0,4'h6);
    tbl[10] = mk(4'hE,2'b00,6'b111000,4'd1,12'h0,4'hF,1,3'd3,0,0,4'h6);
    tbl[11] = mk(4'hE,2'b00,6'b000010,4'd1,12'h0,4'h0,1,3'd4,0,0,4'h6);
    tbl[12] = mk(4'hE,2'b00,6'b011010,4'd1,12'h182,4'h0,1,3'd5,0,1,4'h6);
    tbl[13] = mk(4'hE,2'b11,6'b000000,4'd1,12'h0,4'hF,1,3'd0,0,0,4'h6);
    tbl[14] = mk(4'hE,2'b00,6'b001000,4'd15,12'h0,4'h0,1,3'd0,0,0,4'h6);
    tbl[15] = mk(4'hE,2'b01,6'b011001,4'd15,12'h0,4'h0,1,3'd0,0,0,4'h6);
    tbl[16] = mk(4'hB,2'b00,6'b001001,4'd1,12'h0,4'hF,0,3'd0,0,0,4'h6);
    tbl[17] = mk(4'hF,2'b01,6'b011000,4'd1,12'h0,4'h0,0,3'd0,0,0,4'h6);
    tbl[18] = mk(4'hE,2'b00,6'b000110,4'd1,12'h0,4'h0,1,3'd0,0,0,4'h6);
    tbl[19] = mk(4'hC,2'b00,6'b001000,4'd1,12'h0,4'h0,0,3'd0,0,0,4'h6);

    do_reset();
    #1;
    chk("reset0", 32'(obs(0)),
        32'(pk(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10,
               3'd0, 0, 2'b00)));
    chk("reset2", 32'(obs(1)),
        32'(pk(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10,
               3'd0, 0, 2'b00)));
    chk("reset0 flags", 32'(dut0.flags_q), 32'h0);

    foreach (tbl[i]) run(tbl[i], 0, i);

    // MEM_LAT=2 sequences on a freshly reset instance.
    @(negedge clk);
    do_reset();
    run(tbl[1], 1, 100);
    run(tbl[0], 1, 101);
    r2 = mk(4'hE,2'b00,6'b000101,4'd1,12'h0,4'h8,1,3'd1,0,0,4'h8);
    run(r2, 1, 102);

    // Async reset in the middle of a stretched MEMREAD.
    cond = 4'hE; op = 2'b01; funct = 6'b011001;
    rd = 4'd2; src2 = '0; aflg = 4'h0;
    begin
      int k;
      k = 0;
      while (ifc2.State != 4'd3 && k < 20) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("reach memread", 32'(ifc2.State), 32'd3);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid reset strobes",
        32'({ifc2.State, ifc2.MemWrite, ifc2.RegWrite,
             ifc2.PCWrite, ifc2.IRWrite}), 32'h0);
    chk("mid reset flags", 32'(dut2.flags_q), 32'h0);
    chk("mid reset cnt", 32'(dut2.cnt_q), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post reset cnt", 32'(dut2.cnt_q), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
